// File: rtl/fir_decim_mc.sv
// rtl/fir_decim_mc.sv - lockstep multi-channel decimating FIR with sequential MAC
// FWFT FIFO in, FIFO push out; one shared coefficient set, one MAC per channel.
module fir_decim_mc #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 20,
  parameter int DECIMATION = 1,
  parameter int FRAC_BITS  = 10,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS] = '{default: '0},
  parameter bit SATURATE   = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_dout,
  input  logic [CHANNELS-1:0]            in_empty,
  output logic [CHANNELS-1:0]            in_rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_din,
  input  logic                           out_full,
  output logic                           out_wr_en
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW = $clog2(DECIMATION + 1);
  localparam int PW = 2 * DW;
  localparam int AW = PW + TW;

  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DECIMATION - 1);

  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [TW-1:0] tap;
  logic          rd;
  logic          fill_done;
  logic          mac_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FILL;
      count <= '0;
      tap   <= '0;
    end else begin
      state <= state_next;
      if (state == S_FILL && rd) begin
        count <= (count == LAST_CNT) ? '0 : count + 1'b1;
      end
      if (state == S_MAC) begin
        tap <= mac_last ? '0 : tap + 1'b1;
      end
    end
  end

  // Reads are gated by reset so an upstream FIFO is never popped while held in reset.
  always_comb begin
    state_next = state;
    rd         = 1'b0;
    out_wr_en  = 1'b0;
    case (state)
      S_FILL: begin
        rd = reset & ~|in_empty;
        if (rd && count == LAST_CNT) state_next = S_MAC;
      end
      S_MAC: begin
        if (tap == LAST_TAP) state_next = S_OUT;
      end
      S_OUT: begin
        out_wr_en = ~out_full;
        if (!out_full) state_next = S_FILL;
      end
      default: state_next = S_FILL;
    endcase
  end

  assign in_rd_en  = {CHANNELS{rd}};
  assign fill_done = (state == S_FILL) && rd && (count == LAST_CNT);
  assign mac_last  = (tap == LAST_TAP);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DW-1:0] dline [TAPS];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [AW-1:0] term;
    logic        [DW-1:0] conv;
    logic        [DW-1:0] y;

    assign prod     = COEFFS[tap] * dline[tap];
    assign scaled   = prod >>> FRAC_BITS;
    assign term     = {{TW{scaled[PW-1]}}, scaled};
    assign acc_next = acc + term;

    always_comb begin
      conv = acc_next[DW-1:0];
      if (SATURATE && acc_next > MAXV) conv = {1'b0, {(DW-1){1'b1}}};
      else if (SATURATE && acc_next < MINV) conv = {1'b1, {(DW-1){1'b0}}};
    end

    // History persists across blocks; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < TAPS; k++) dline[k] <= '0;
        acc <= '0;
        y   <= '0;
      end else begin
        if (state == S_FILL && rd) begin
          dline[0] <= in_dout[c*DW +: DW];
          for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
          if (fill_done) acc <= '0;
        end
        if (state == S_MAC) begin
          acc <= acc_next;
          if (mac_last) y <= conv;
        end
      end
    end

    assign out_din[c*DW +: DW] = y;
  end

endmodule

// File: doc/fir_decim_mc.md
Name: fir_decim_mc

Overview:
- Parametrised multi-channel FIR filter with decimation and a FIFO handshake on both sides; the successor to the single complex and real FIR stages in the radio datapath.
- CHANNELS independent data channels share one coefficient set and advance in lockstep: I/Q with CHANNELS=2, or the L/R audio path.
- Sits between upstream FWFT FIFOs and downstream FIFOs.
- New relative to the existing stages: arbitrary channel count, optional output saturation, sequential MAC.

Parameters:
- CHANNELS, 2, number of lockstep data channels.
- DATA_WIDTH, 32, signed sample, coefficient and output width.
- TAPS, 20, filter length (>=2).
- DECIMATION, 1, input samples consumed per output sample (>=1).
- FRAC_BITS, 10, dequantize shift applied to each product.
- COEFFS, all zero, array [TAPS] of signed DATA_WIDTH coefficients; COEFFS[0] multiplies the newest sample.
- SATURATE, 0, 1 = clamp output to the DATA_WIDTH signed range, 0 = truncate to low bits.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_dout  in  CHANNELS*DATA_WIDTH  upstream FWFT FIFO data, channel c at bits [c*DW +: DW].
- in_empty  in  CHANNELS  per-channel upstream empty flags.
- in_rd_en  out  CHANNELS  per-channel pop strobes; all bits are always equal.
- out_din  out  CHANNELS*DATA_WIDTH  filtered output, same packing as in_dout.
- out_full  in  1  downstream full (any channel's FIFO full).
- out_wr_en  out  1  downstream push strobe, shared by all channels.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_FILL, sample count=0, tap index=0.
  - All delay lines and accumulators = 0.
  - out_din=0, out_wr_en=0, in_rd_en=0.
  - A reset asserted mid-operation discards any partial block; no write occurs.
- S_FILL:
  - in_rd_en = {CHANNELS{~|in_empty}}, combinational.
  - On each cycle with a read, every channel's delay line shifts: x[k]<=x[k-1], x[0]<=in_dout slice. Count increments.
  - If any in_empty bit is high: no channel reads and nothing shifts. Channels never skew.
  - On the read that makes count==DECIMATION: count<=0, accumulators<=0, go to S_MAC.
- S_MAC:
  - Lasts TAPS cycles with tap index k=0..TAPS-1.
  - Per channel: acc += (COEFFS[k]*x[k]) >>> FRAC_BITS, i.e. full 2*DW product, arithmetic shift, accumulator 2*DW+clog2(TAPS) wide.
  - No reads in this state.
  - After k=TAPS-1: register out_din (apply saturation or truncation), go to S_OUT.
- S_OUT:
  - out_wr_en = ~out_full, combinational from the registered state.
  - out_din is held stable until written.
  - On the write cycle go to S_FILL.
  - While out_full=1: hold state, out_din stable, no reads (backpressure propagates upstream).
- Output conversion:
  - SATURATE=1: acc > 2^(DW-1)-1 gives 0x7FF..F; acc < -2^(DW-1) gives 0x800..0.
  - SATURATE=0: out = acc[DW-1:0].
- Latency and throughput:
  - Last input read of a block to out_wr_en high = TAPS+1 cycles when out_full=0.
  - Peak throughput is one output per DECIMATION+TAPS+1 cycles.
- Delay-line history is retained across blocks and is zero only after reset. Initial outputs therefore reflect zero history.
- Simultaneous events: reads never occur in S_OUT, so a write and a read never share a cycle.

Test Plan:
- Impulse, CHANNELS=2, TAPS=4, DECIMATION=1, FRAC_BITS=10, COEFFS={1024,2048,-1024,512}:
  - ch0 input = 1024,0,0,0,0 -> ch0 outputs 1024, 2048, -1024, 512, 0.
  - ch1 constant 100 -> ch1 outputs 100, 300, 200, 250, 250.
- Decimation, same coefficients, DECIMATION=2, ch1 constant 100 -> outputs 300, 250, 250. One out_wr_en per 2 reads, spacing 2+4+1=7 cycles.
- Backpressure: hold out_full=1 for 20 cycles in S_OUT -> out_wr_en=0 and out_din unchanged throughout, in_rd_en=0. The write occurs the first cycle out_full=0.
- Channel skew: in_empty=2'b10 for 5 cycles with ch0 data present -> in_rd_en=2'b00. Delay lines unchanged; later outputs identical to the no-stall run.
- Saturation: COEFFS all 1024, input 0x7FFFFFFF on all taps:
  - SATURATE=1 -> out 0x7FFFFFFF.
  - SATURATE=0 -> out 0xFFFFFFFC (low 32 bits of 4*(2^31-1)).
- Reset mid-S_MAC: pull reset low at k=2 -> outputs 0 immediately, with no out_wr_en. After release, the impulse test reproduces exactly from zero history.
